// File: rtl/tone_counter.sv
// Programmable step counter for the sound generator: free-run, modulo and
// one-shot modes, up/down, with registered terminal-count pulse and toggle.
module tone_counter #(
  parameter int unsigned BW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [BW-1:0] load_val_i,
  input  logic [BW-1:0] limit_i,
  input  logic          dir_i,
  input  logic [1:0]    mode_i,
  output logic [BW-1:0] counter_val_o,
  output logic          tc_o,
  output logic          toggle_o,
  output logic          halted_o
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  localparam logic [1:0]    MODE_FREE    = 2'b00;
  localparam logic [1:0]    MODE_ONESHOT = 2'b10;
  localparam logic [BW-1:0] ONE          = {{(BW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [BW-1:0] count_q, count_d;
  logic          tc_q, tc_d;
  logic          toggle_q, toggle_d;

  logic          is_free;
  logic          is_oneshot;
  logic          term;
  logic [BW-1:0] count_step;

  // Mode 11 falls through to the modulo behaviour.
  assign is_free    = (mode_i == MODE_FREE);
  assign is_oneshot = (mode_i == MODE_ONESHOT);
  assign term       = dir_i   ? (count_q == '0) :
                      is_free ? (count_q == '1) :
                                (count_q >= limit_i);
  assign count_step = dir_i ? (count_q - ONE) : (count_q + ONE);

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a combinational output unassigned and no latch is inferred.
    state_d  = state_q;
    count_d  = count_q;
    tc_d     = 1'b0;
    toggle_d = toggle_q;

    if (load_i) begin
      count_d = load_val_i;
      state_d = RUN;
    end else if (state_q == HALT) begin
      if (!is_oneshot) state_d = RUN;
    end else if (en_i) begin
      if (!term) begin
        count_d = count_step;
      end else begin
        tc_d     = 1'b1;
        toggle_d = ~toggle_q;
        if (is_oneshot) begin
          state_d = HALT;
        end else if (is_free) begin
          count_d = count_step;
        end else begin
          count_d = dir_i ? limit_i : '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments let every flop sample the pre-edge
    // values, independent of statement order.
    if (rst_i) begin
      state_q  <= RUN;
      count_q  <= '0;
      tc_q     <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      tc_q     <= tc_d;
      toggle_q <= toggle_d;
    end
  end

  assign counter_val_o = count_q;
  assign tc_o          = tc_q;
  assign toggle_o      = toggle_q;
  assign halted_o      = (state_q == HALT);

endmodule
